slot_credit_ledger: RTL and testbench

Parametrised credit/balance manager for the slot-machine datapath. It replaces the fixed 9-bit add-only balance block.
- Adds: bet debiting with a spin request/grant handshake, coin insertion, a per-level payout table, saturating arithmetic, insufficient-funds denial and a spin counter.
- Sits between the reel/match logic, which supplies the win level, and the balance display/BCD path.

---
 rtl/slot_pkg.sv | 20 ++
 rtl/slot_sat_addsub.sv | 24 ++
 rtl/slot_credit_ledger.sv | 116 +++++++++++
 tb/tb_slot_credit_ledger.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared types and default payout constants for the slot-machine credit path.
package slot_pkg;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_TWO   = 2'b01,
    WIN_THREE = 2'b10,
    WIN_FOUR  = 2'b11
  } win_level_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ledger_state_t;

  localparam int DEF_PAY_TWO   = 2;
  localparam int DEF_PAY_THREE = 3;
  localparam int DEF_PAY_FOUR  = 4;

endpackage

// File: rtl/slot_sat_addsub.sv
// Combinational base + add_a + add_b - sub, clamped to all-ones; zero latency, no flow control.
// Callers guarantee sub <= base + add_a + add_b, so only the upper bound is clamped.
module slot_sat_addsub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] sub,
  output logic [WIDTH-1:0] result,
  output logic             sat
);

  localparam logic [WIDTH+1:0] MAX_EXT = {2'b00, {WIDTH{1'b1}}};

  logic [WIDTH+1:0] sum;

  always_comb begin
    sum    = {2'b00, base} + {2'b00, add_a} + {2'b00, add_b} - {2'b00, sub};
    sat    = (sum > MAX_EXT);
    result = sat ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/slot_credit_ledger.sv
// Credit ledger: bet debit on spin grant, coin credit, per-level payout, saturating balance.
// All outputs registered, one cycle after the triggering input; requests in WAIT are ignored, never queued.
module slot_credit_ledger
  import slot_pkg::*;
#(
  parameter int WIDTH       = 9,
  parameter int INIT_CREDIT = 10,
  parameter int BET         = 1,
  parameter int COIN_VALUE  = 5,
  parameter int PAY_TWO     = DEF_PAY_TWO,
  parameter int PAY_THREE   = DEF_PAY_THREE,
  parameter int PAY_FOUR    = DEF_PAY_FOUR,
  parameter int SPIN_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spin_req,
  output logic              spin_grant,
  output logic              spin_denied,
  input  logic              result_valid,
  input  logic [1:0]        result_level,
  input  logic              coin_in,
  output logic [WIDTH-1:0]  balance,
  output logic              busy,
  output logic              payout_done,
  output logic              sat_flag,
  output logic [SPIN_W-1:0] spin_count
);

  localparam logic [WIDTH-1:0] INIT_W  = WIDTH'(INIT_CREDIT);
  localparam logic [WIDTH-1:0] BET_W   = WIDTH'(BET);
  localparam logic [WIDTH-1:0] COIN_W  = WIDTH'(COIN_VALUE);
  localparam logic [WIDTH-1:0] PAY2_W  = WIDTH'(PAY_TWO);
  localparam logic [WIDTH-1:0] PAY3_W  = WIDTH'(PAY_THREE);
  localparam logic [WIDTH-1:0] PAY4_W  = WIDTH'(PAY_FOUR);

  ledger_state_t    state;
  logic             grant_now;
  logic             deny_now;
  logic             result_now;
  logic [WIDTH-1:0] coin_add;
  logic [WIDTH-1:0] pay_add;
  logic [WIDTH-1:0] debit;
  logic [WIDTH-1:0] next_balance;
  logic             next_sat;

  // Funds check uses the registered (pre-coin) balance, so a same-cycle coin cannot rescue a denial.
  always_comb begin
    grant_now  = (state == IDLE) && spin_req && (balance >= BET_W);
    deny_now   = (state == IDLE) && spin_req && (balance <  BET_W);
    result_now = (state == WAIT) && result_valid;
    coin_add   = coin_in   ? COIN_W : '0;
    debit      = grant_now ? BET_W  : '0;
    pay_add    = '0;
    if (result_now) begin
      case (win_level_t'(result_level))
        WIN_TWO:   pay_add = PAY2_W;
        WIN_THREE: pay_add = PAY3_W;
        WIN_FOUR:  pay_add = PAY4_W;
        default:   pay_add = '0;
      endcase
    end
  end

  slot_sat_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .base   (balance),
    .add_a  (coin_add),
    .add_b  (pay_add),
    .sub    (debit),
    .result (next_balance),
    .sat    (next_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      balance     <= INIT_W;
      spin_grant  <= 1'b0;
      spin_denied <= 1'b0;
      payout_done <= 1'b0;
      busy        <= 1'b0;
      sat_flag    <= 1'b0;
      spin_count  <= '0;
    end else begin
      balance     <= next_balance;
      spin_grant  <= grant_now;
      spin_denied <= deny_now;
      payout_done <= result_now;
      if (next_sat) begin
        sat_flag <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (grant_now) begin
            state      <= WAIT;
            busy       <= 1'b1;
            spin_count <= spin_count + 1'b1;
          end
        end
        WAIT: begin
          if (result_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slot_credit_ledger.sv
// Scoreboard bench for slot_credit_ledger: stimulus pushes expected pulse records, a monitor pops on each pulse.
module tb_slot_credit_ledger;

  localparam int K_GRANT = 0;
  localparam int K_DENY  = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int kind;
    int bal;
    int busy;
    int cnt;
    int sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spin_req = 1'b0;
  logic        spin_grant;
  logic        spin_denied;
  logic        result_valid = 1'b0;
  logic [1:0]  result_level = 2'b00;
  logic        coin_in = 1'b0;
  logic [8:0]  balance;
  logic        busy;
  logic        payout_done;
  logic        sat_flag;
  logic [15:0] spin_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  slot_credit_ledger dut (
    .clk          (clk),
    .reset        (reset),
    .spin_req     (spin_req),
    .spin_grant   (spin_grant),
    .spin_denied  (spin_denied),
    .result_valid (result_valid),
    .result_level (result_level),
    .coin_in      (coin_in),
    .balance      (balance),
    .busy         (busy),
    .payout_done  (payout_done),
    .sat_flag     (sat_flag),
    .spin_count   (spin_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int kind, input int bal, input int bsy, input int cnt, input int sat);
    exp_t e;
    e.kind = kind; e.bal = bal; e.busy = bsy; e.cnt = cnt; e.sat = sat;
    sb.push_back(e);
  endtask

  // Monitor: every output pulse must match the oldest expected record.
  initial begin
    exp_t e;
    int   kind;
    forever begin
      @(negedge clk);
      if (spin_grant || spin_denied || payout_done) begin
        kind = spin_grant ? K_GRANT : (spin_denied ? K_DENY : K_DONE);
        if (sb.size() == 0) begin
          check("unexpected_pulse_kind", kind, -1);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", kind, e.kind);
          check("pulse_count", int'(spin_grant) + int'(spin_denied) + int'(payout_done), 1);
          check("pulse_balance", int'(balance), e.bal);
          check("pulse_busy", int'(busy), e.busy);
          check("pulse_spin_count", int'(spin_count), e.cnt);
          check("pulse_sat_flag", int'(sat_flag), e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int bal, input int cnt, input int sat);
    check({tag, "_balance"}, int'(balance), bal);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_spin_count"}, int'(spin_count), cnt);
    check({tag, "_sat_flag"}, int'(sat_flag), sat);
    check({tag, "_pulses"}, int'(spin_grant) + int'(spin_denied) + int'(payout_done), 0);
  endtask

  // Grant then result; expectations are the balance/count after each step.
  task automatic spin(input logic [1:0] lvl, input logic coin_req, input logic coin_res,
                      input int g_bal, input int cnt, input int d_bal, input int sat);
    @(negedge clk);
    spin_req = 1'b1;
    coin_in  = coin_req;
    push(K_GRANT, g_bal, 1, cnt, sat);
    @(negedge clk);
    spin_req     = 1'b0;
    result_valid = 1'b1;
    result_level = lvl;
    coin_in      = coin_res;
    push(K_DONE, d_bal, 0, cnt, sat);
    @(negedge clk);
    result_valid = 1'b0;
    coin_in      = 1'b0;
  endtask

  initial begin
    // 1: reset state
    repeat (2) @(negedge clk);
    check_idle("reset", 10, 0, 0);
    reset = 1'b0;

    // 2: win spin, four-match pays 4
    spin(2'b11, 1'b0, 1'b0, 9, 1, 13, 0);

    // 3: drain to zero with losing spins, then denial
    do_reset(2);
    check_idle("reset2", 10, 0, 0);
    for (int i = 0; i < 10; i++) begin
      spin(2'b00, 1'b0, 1'b0, 9 - i, i + 1, 9 - i, 0);
    end
    @(negedge clk);
    spin_req = 1'b1;
    push(K_DENY, 0, 0, 10, 0);
    @(negedge clk);
    spin_req = 1'b0;
    @(negedge clk);
    check_idle("after_deny", 0, 10, 0);
    // result_valid in IDLE must not pay
    result_valid = 1'b1;
    result_level = 2'b11;
    @(negedge clk);
    result_valid = 1'b0;
    @(negedge clk);
    check_idle("idle_result", 0, 10, 0);
    // a coin in the same cycle does not rescue a denial
    spin_req = 1'b1;
    coin_in  = 1'b1;
    push(K_DENY, 5, 0, 10, 0);
    @(negedge clk);
    spin_req = 1'b0;
    coin_in  = 1'b0;
    @(negedge clk);
    check_idle("coin_no_rescue", 5, 10, 0);

    // 4: saturation 5 + 101*5 = 510, then one more coin clamps to 511
    for (int i = 0; i < 101; i++) begin
      coin_in = 1'b1;
      @(negedge clk);
    end
    coin_in = 1'b0;
    check_idle("coins_510", 510, 10, 0);
    coin_in = 1'b1;
    @(negedge clk);
    coin_in = 1'b0;
    check_idle("coin_clamp", 511, 10, 1);
    spin(2'b00, 1'b0, 1'b0, 510, 11, 510, 1);

    // 5: simultaneous coin with result, then coin with grant
    do_reset(2);
    check_idle("reset3", 10, 0, 0);
    spin(2'b01, 1'b0, 1'b1, 9, 1, 16, 0);
    spin(2'b10, 1'b1, 1'b0, 20, 2, 23, 0);

    // 6: reset while waiting for a result
    @(negedge clk);
    spin_req = 1'b1;
    push(K_GRANT, 22, 1, 3, 0);
    @(negedge clk);
    spin_req = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("mid_reset", 10, 0, 0);
    @(negedge clk);
    result_valid = 1'b1;
    result_level = 2'b11;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("post_reset_result", 10, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
